// File: rtl/vga_timing_pkg.sv
// Timing constants for 640x480@60 Hz VGA from a 25 MHz pixel clock.
package vga_timing_pkg;
  localparam int COORD_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam bit SYNC_POL  = 1'b0;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [START, END)
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
endpackage

// File: rtl/vga_sync_gen_if.sv
// Registered VGA timing outputs: sync pins plus pixel coordinates for the colour pipeline.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [COORD_W-1:0] pixel_col;
  logic [COORD_W-1:0] pixel_row;
  logic               frame_start;

  modport master (output hsync, vsync, video_on, pixel_col, pixel_row, frame_start);
  modport slave  (input  hsync, vsync, video_on, pixel_col, pixel_row, frame_start);
endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULO up counter with synchronous clear; wrap marks the enabled terminal count.
module mod_counter #(
  parameter int WIDTH  = 10,
  parameter int MODULO = 800
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_count;

  // >= rather than == so an out-of-range value can never run away; it wraps to 0.
  assign wrap  = en & (r_count >= LAST);
  assign count = r_count;

  // Count on enable, wrap at terminal count, clear has priority.
  always_ff @(posedge clk) begin
    if (clr)
      r_count <= '0;
    else if (en)
      r_count <= wrap ? '0 : r_count + 1'b1;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v counters plus one output register stage, all outputs aligned.
module vga_sync_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            locked,
  vga_sync_gen_if.master  vga
);
  localparam int CW      = vga_timing_pkg::COORD_W;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_VIS_END = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_VISIBLE + V_FP + V_SYNC);

  logic          w_clr;
  logic          w_h_wrap;
  logic          w_v_wrap_unused;
  logic [CW-1:0] w_h_cnt;
  logic [CW-1:0] w_v_cnt;
  logic          w_h_sync_win;
  logic          w_v_sync_win;
  logic          w_visible;

  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic [CW-1:0] r_pixel_col;
  logic [CW-1:0] r_pixel_row;
  logic          r_frame_start;

  // Losing PLL lock is treated exactly like reset; both are sampled on refclk only.
  assign w_clr = rst | ~locked;

  mod_counter #(.WIDTH(CW), .MODULO(H_TOTAL)) u_h_cnt (
    .clk   (refclk),
    .clr   (w_clr),
    .en    (1'b1),
    .count (w_h_cnt),
    .wrap  (w_h_wrap)
  );

  // Row advances only at end of line; its own wrap is implicit in the count.
  mod_counter #(.WIDTH(CW), .MODULO(V_TOTAL)) u_v_cnt (
    .clk   (refclk),
    .clr   (w_clr),
    .en    (w_h_wrap),
    .count (w_v_cnt),
    .wrap  (w_v_wrap_unused)
  );

  assign w_h_sync_win = (w_h_cnt >= H_SYNC_LO) && (w_h_cnt < H_SYNC_HI);
  assign w_v_sync_win = (w_v_cnt >= V_SYNC_LO) && (w_v_cnt < V_SYNC_HI);
  assign w_visible    = (w_h_cnt < H_VIS_END) && (w_v_cnt < V_VIS_END);

  // Register every output from the same counter state so they stay mutually aligned.
  always_ff @(posedge refclk) begin
    if (w_clr) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_pixel_col   <= '0;
      r_pixel_row   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_h_sync_win ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_v_sync_win ? SYNC_POL : ~SYNC_POL;
      r_video_on    <= w_visible;
      r_pixel_col   <= w_h_cnt;
      r_pixel_row   <= w_v_cnt;
      r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.video_on    = r_video_on;
  assign vga.pixel_col   = r_pixel_col;
  assign vga.pixel_row   = r_pixel_row;
  assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size active-low instance for line timing, shrunk active-high instance for frame timing.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  // Shrunk timing for frame-level checks: H_TOTAL 25, V_TOTAL 19, frame 475.
  localparam int BH_VIS = 16, BH_FP = 2, BH_SY = 4, BH_BP = 3;
  localparam int BV_VIS = 12, BV_FP = 2, BV_SY = 2, BV_BP = 3;
  localparam int BH_TOT = BH_VIS + BH_FP + BH_SY + BH_BP;
  localparam int BV_TOT = BV_VIS + BV_FP + BV_SY + BV_BP;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] col;
    logic [9:0] row;
    logic       fs;
  } obs_t;

  logic refclk = 1'b0;
  logic rst_a = 1'b1, locked_a = 1'b1;
  logic rst_b = 1'b1, locked_b = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #20 refclk = ~refclk;

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();

  vga_sync_gen u_dut_a (
    .refclk (refclk),
    .rst    (rst_a),
    .locked (locked_a),
    .vga    (vga_a)
  );

  vga_sync_gen #(
    .H_VISIBLE (BH_VIS), .H_FP (BH_FP), .H_SYNC (BH_SY), .H_BP (BH_BP),
    .V_VISIBLE (BV_VIS), .V_FP (BV_FP), .V_SYNC (BV_SY), .V_BP (BV_BP),
    .SYNC_POL  (1'b1)
  ) u_dut_b (
    .refclk (refclk),
    .rst    (rst_b),
    .locked (locked_b),
    .vga    (vga_b)
  );

  function automatic obs_t reset_obs(bit pol);
    obs_t r;
    r     = '0;
    r.hs  = ~pol;
    r.vs  = ~pol;
    return r;
  endfunction

  function automatic obs_t model(int hc, int vc, int hvis, int hfp, int hsy,
                                 int vvis, int vfp, int vsy, bit pol);
    obs_t r;
    r.hs  = (hc >= hvis + hfp && hc < hvis + hfp + hsy) ? pol : ~pol;
    r.vs  = (vc >= vvis + vfp && vc < vvis + vfp + vsy) ? pol : ~pol;
    r.von = (hc < hvis) && (vc < vvis);
    r.col = 10'(hc);
    r.row = 10'(vc);
    r.fs  = (hc == 0) && (vc == 0);
    return r;
  endfunction

  // Scoreboard: the model predicts each edge's outputs, compared half a cycle later.
  obs_t q_a[$];
  obs_t q_b[$];
  int   hc_a = 0, vc_a = 0, hc_b = 0, vc_b = 0;

  always @(posedge refclk) begin
    if (rst_a || !locked_a) begin
      q_a.push_back(reset_obs(1'b0));
      hc_a = 0; vc_a = 0;
    end else begin
      q_a.push_back(model(hc_a, vc_a, H_VISIBLE, H_FP, H_SYNC, V_VISIBLE, V_FP, V_SYNC, 1'b0));
      if (hc_a == H_TOTAL - 1) begin
        hc_a = 0;
        vc_a = (vc_a == V_TOTAL - 1) ? 0 : vc_a + 1;
      end else hc_a++;
    end
    if (rst_b || !locked_b) begin
      q_b.push_back(reset_obs(1'b1));
      hc_b = 0; vc_b = 0;
    end else begin
      q_b.push_back(model(hc_b, vc_b, BH_VIS, BH_FP, BH_SY, BV_VIS, BV_FP, BV_SY, 1'b1));
      if (hc_b == BH_TOT - 1) begin
        hc_b = 0;
        vc_b = (vc_b == BV_TOT - 1) ? 0 : vc_b + 1;
      end else hc_b++;
    end
  end

  always @(negedge refclk) begin
    obs_t e, o;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      o = {vga_a.hsync, vga_a.vsync, vga_a.video_on, vga_a.pixel_col, vga_a.pixel_row, vga_a.frame_start};
      n_cmp++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL sb_a observed=%h expected=%h", o, e);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      o = {vga_b.hsync, vga_b.vsync, vga_b.video_on, vga_b.pixel_col, vga_b.pixel_row, vga_b.frame_start};
      n_cmp++;
      assert (o === e) else begin
        n_err++;
        $error("FAIL sb_b observed=%h expected=%h", o, e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int von_cnt, von_end, hs_cnt, hs_first, hs_last, fs_cnt, col_bad;
    int k_fs2, vs_cnt, vs_row, n_wrap, pcol, prow;
    bit found;

    // Reset held for three cycles with lock present.
    repeat (3) @(negedge refclk);
    chk("rst_a_hsync", vga_a.hsync, 1);
    chk("rst_a_vsync", vga_a.vsync, 1);
    chk("rst_a_video_on", vga_a.video_on, 0);
    chk("rst_a_col", vga_a.pixel_col, 0);
    chk("rst_a_row", vga_a.pixel_row, 0);
    chk("rst_a_frame_start", vga_a.frame_start, 0);
    chk("rst_b_hsync_pol1", vga_b.hsync, 0);
    chk("rst_b_vsync_pol1", vga_b.vsync, 0);

    // First line of the full-size instance.
    rst_a = 1'b0;
    @(negedge refclk);
    chk("a_first_frame_start", vga_a.frame_start, 1);
    chk("a_first_video_on", vga_a.video_on, 1);
    chk("a_first_col", vga_a.pixel_col, 0);
    von_cnt = 1; von_end = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    fs_cnt = 0; col_bad = 0;
    for (int c = 1; c < 800; c++) begin
      @(negedge refclk);
      if (vga_a.pixel_col !== 10'(c)) col_bad++;
      if (vga_a.video_on === 1'b1) von_cnt++;
      else if (von_end < 0) von_end = c;
      if (vga_a.hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (vga_a.frame_start === 1'b1) fs_cnt++;
    end
    chk("a_col_sequence_errors", col_bad, 0);
    chk("a_video_on_count", von_cnt, 640);
    chk("a_video_off_col", von_end, 640);
    chk("a_hsync_width", hs_cnt, 96);
    chk("a_hsync_first_col", hs_first, 656);
    chk("a_hsync_last_col", hs_last, 751);
    chk("a_no_extra_frame_start", fs_cnt, 0);
    @(negedge refclk);
    chk("a_line_wrap_col", vga_a.pixel_col, 0);
    chk("a_line_wrap_row", vga_a.pixel_row, 1);

    // Reset while hsync is active.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge refclk);
      if (vga_a.pixel_col == 10'd700) found = 1'b1;
    end
    chk("a_reach_col700", found, 1);
    chk("a_hsync_active_col700", vga_a.hsync, 0);
    rst_a = 1'b1;
    @(negedge refclk);
    chk("a_rst_hsync_inactive", vga_a.hsync, 1);
    chk("a_rst_col", vga_a.pixel_col, 0);
    chk("a_rst_video_on", vga_a.video_on, 0);
    rst_a = 1'b0;

    // Frame-level timing on the shrunk active-high instance.
    rst_b = 1'b0;
    @(negedge refclk);
    chk("b_first_frame_start", vga_b.frame_start, 1);
    k_fs2 = -1; vs_cnt = 0; vs_row = -1; n_wrap = 0; fs_cnt = 0;
    pcol = 0; prow = 0;
    for (int k = 1; k <= 2 * BH_TOT * BV_TOT; k++) begin
      @(negedge refclk);
      if (vga_b.frame_start === 1'b1) begin
        fs_cnt++;
        if (k_fs2 < 0) k_fs2 = k;
      end
      if (k < BH_TOT * BV_TOT && vga_b.vsync === 1'b1) begin
        vs_cnt++;
        if (vs_row < 0) vs_row = int'(vga_b.pixel_row);
      end
      if (pcol == BH_TOT - 1 && prow == BV_TOT - 1) begin
        n_wrap++;
        chk("b_wrap_to_origin", {vga_b.pixel_col, vga_b.pixel_row}, 20'd0);
      end
      pcol = int'(vga_b.pixel_col);
      prow = int'(vga_b.pixel_row);
    end
    chk("b_frame_period", k_fs2, BH_TOT * BV_TOT);
    chk("b_frame_start_count", fs_cnt, 2);
    chk("b_vsync_width", vs_cnt, 2 * BH_TOT);
    chk("b_vsync_first_row", vs_row, 14);
    chk("b_wrap_count", n_wrap, 2);

    // Lock loss mid-frame acts as reset; relock restarts at origin.
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge refclk);
      if (vga_b.pixel_col == 10'd3 && vga_b.pixel_row == 10'd5) found = 1'b1;
    end
    chk("b_reach_col3_row5", found, 1);
    locked_b = 1'b0;
    @(negedge refclk);
    chk("b_unlock_hsync", vga_b.hsync, 0);
    chk("b_unlock_vsync", vga_b.vsync, 0);
    chk("b_unlock_video_on", vga_b.video_on, 0);
    chk("b_unlock_col", vga_b.pixel_col, 0);
    chk("b_unlock_row", vga_b.pixel_row, 0);
    chk("b_unlock_frame_start", vga_b.frame_start, 0);
    locked_b = 1'b1;
    @(negedge refclk);
    chk("b_relock_frame_start", vga_b.frame_start, 1);
    chk("b_relock_col", vga_b.pixel_col, 0);
    chk("b_relock_row", vga_b.pixel_row, 0);
    chk("b_relock_video_on", vga_b.video_on, 1);

    repeat (4) @(negedge refclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
